// File: rtl/button_event_decoder_pkg.sv
// button_event_decoder_pkg: shared state encoding and parameter range helper for the button decoder.
package button_event_decoder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } state_t;
  function automatic bit cnt_legal(input longint unsigned v, input longint unsigned lo, input int w);
    return v >= lo && v <= (64'd1 << w) - 64'd1;
  endfunction
endpackage

// File: rtl/button_event_decoder_edge_detect.sv
// edge_detect: one-cycle delayed copy of a level plus single-cycle rise/fall strobes.
module edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);
  logic r_q;
  always_ff @(posedge i_clk) r_q <= i_rst ? 1'b0 : i_sig;
  assign o_rise = i_sig & ~r_q;
  assign o_fall = ~i_sig & r_q;
endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced button level into press/release/click/long/repeat pulses.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int          CNT_W      = 24,
  parameter int unsigned LONG_CNT   = 24'hFF_FFFF,
  parameter int unsigned REPEAT_CNT = 24'h3F_FFFF,
  parameter bit          REPEAT_EN  = 1'b1
) (
  input  logic clkIn,
  input  logic rstIn,
  input  logic buttonIn,
  output logic heldOut,
  output logic pressOut,
  output logic releaseOut,
  output logic clickOut,
  output logic longPressOut,
  output logic repeatOut
);
  if (!cnt_legal(LONG_CNT, 2, CNT_W)) begin : g_bad_long
    $error("LONG_CNT must be in 2..2^CNT_W-1");
  end
  if (!cnt_legal(REPEAT_CNT, 1, CNT_W)) begin : g_bad_repeat
    $error("REPEAT_CNT must be in 1..2^CNT_W-1");
  end
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 1);
  logic w_rise, w_fall;
  state_t r_state;
  logic [CNT_W-1:0] r_timer;
  logic r_held, r_press, r_release, r_click, r_long, r_repeat;
  edge_detect u_edge (
    .i_clk (clkIn),
    .i_rst (rstIn),
    .i_sig (buttonIn),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );
  // A fall is tested before the timer match in every state so release always wins a tie.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_held    <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_click   <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_click   <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_rise) begin
          r_state <= ST_PRESSED;
          r_timer <= '0;
          r_press <= 1'b1;
          r_held  <= 1'b1;
        end
        ST_PRESSED: if (w_fall) begin
          r_state   <= ST_IDLE;
          r_timer   <= '0;
          r_held    <= 1'b0;
          r_release <= 1'b1;
          r_click   <= 1'b1;
        end else if (r_timer == LONG_LAST && buttonIn) begin
          r_state <= ST_LONG_HELD;
          r_timer <= '0;
          r_long  <= 1'b1;
        end else r_timer <= r_timer + 1'b1;
        ST_LONG_HELD: if (w_fall) begin
          r_state   <= ST_IDLE;
          r_timer   <= '0;
          r_held    <= 1'b0;
          r_release <= 1'b1;
        end else if (REPEAT_EN && r_timer == REP_LAST && buttonIn) begin
          r_timer  <= '0;
          r_repeat <= 1'b1;
        end else r_timer <= REPEAT_EN ? r_timer + 1'b1 : '0;
        default: begin
          r_state <= ST_IDLE;
          r_timer <= '0;
          r_held  <= 1'b0;
        end
      endcase
    end
  end
  assign heldOut      = r_held;
  assign pressOut     = r_press;
  assign releaseOut   = r_release;
  assign clickOut     = r_click;
  assign longPressOut = r_long;
  assign repeatOut    = r_repeat;
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: scenario and random checks of two decoders (repeat on/off) against a hold-length model.
module tb_button_event_decoder;
  localparam int LONG = 8;
  localparam int REP  = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_a = 1'b0;
  logic btn_b = 1'b0;
  logic held_a, press_a, rel_a, click_a, long_a, rpt_a;
  logic held_b, press_b, rel_b, click_b, long_b, rpt_b;
  int checks = 0;
  int errors = 0;
  bit prev[2];
  int h[2];
  logic [5:0] exp_v[2];
  logic [5:0] obs_a, obs_b;
  always #5 clk = ~clk;
  button_event_decoder #(.CNT_W(24), .LONG_CNT(LONG), .REPEAT_CNT(REP), .REPEAT_EN(1'b1)) dut_a (
    .clkIn(clk), .rstIn(rst), .buttonIn(btn_a), .heldOut(held_a), .pressOut(press_a),
    .releaseOut(rel_a), .clickOut(click_a), .longPressOut(long_a), .repeatOut(rpt_a)
  );
  button_event_decoder #(.CNT_W(24), .LONG_CNT(LONG), .REPEAT_CNT(REP), .REPEAT_EN(1'b0)) dut_b (
    .clkIn(clk), .rstIn(rst), .buttonIn(btn_b), .heldOut(held_b), .pressOut(press_b),
    .releaseOut(rel_b), .clickOut(click_b), .longPressOut(long_b), .repeatOut(rpt_b)
  );
  assign obs_a = {held_a, press_a, rel_a, click_a, long_a, rpt_a};
  assign obs_b = {held_b, press_b, rel_b, click_b, long_b, rpt_b};
  // Model: h = number of consecutive samples of 1 since the button last went up.
  task automatic model(input int i, input bit b, input bit r, input bit en);
    bit prs, rel, ck, lng, rpt;
    if (r) begin
      prev[i] = 1'b0;
      h[i] = 0;
      exp_v[i] = '0;
    end else begin
      prs = b && !prev[i];
      rel = !b && prev[i];
      ck = rel && h[i] <= LONG;
      h[i] = b ? (prs ? 1 : h[i] + 1) : 0;
      lng = b && h[i] == LONG + 1;
      rpt = b && en && h[i] > LONG + 1 && (h[i] - LONG - 1) % REP == 0;
      exp_v[i] = {b, prs, rel, ck, lng, rpt};
      prev[i] = b;
    end
  endtask
  task automatic step(input bit a, input bit b, input bit r);
    @(negedge clk);
    btn_a = a;
    btn_b = b;
    rst = r;
    @(posedge clk);
    model(0, a, r, 1'b1);
    model(1, b, r, 1'b0);
    #1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(i[0], ~i[0], 1'b1);
      checks++;
      if ({obs_a, obs_b} !== 12'h000) begin
        errors++;
        $display("FAIL reset cyc %0d got %b_%b want 0", i, obs_a, obs_b);
      end
    end
  endtask
  task automatic test_short_press();
    for (int i = 0; i < 9; i++) begin
      step(i < 5, i < 5, 1'b0);
      checks++;
      if ({obs_a, obs_b} !== {exp_v[0], exp_v[1]}) begin
        errors++;
        $display("FAIL short cyc %0d got %b_%b want %b_%b", i, obs_a, obs_b, exp_v[0], exp_v[1]);
      end
    end
  endtask
  task automatic test_long_repeat();
    int n_long = 0, n_rpt = 0, n_click = 0, t_long = -1;
    for (int i = 0; i < 24; i++) begin
      step(i < 20, i < 20, 1'b0);
      n_long += int'(long_a);
      n_rpt += int'(rpt_a);
      n_click += int'(click_a);
      if (long_a) t_long = i + 1;
      checks++;
      if ({obs_a, obs_b} !== {exp_v[0], exp_v[1]}) begin
        errors++;
        $display("FAIL long_repeat cyc %0d got %b_%b want %b_%b", i, obs_a, obs_b, exp_v[0], exp_v[1]);
      end
    end
    checks++;
    if (n_long != 1 || n_rpt != 2 || n_click != 0 || t_long != 9) begin
      errors++;
      $display("FAIL long_repeat counts got long=%0d@T+%0d rpt=%0d click=%0d want 1@T+9 2 0", n_long, t_long, n_rpt, n_click);
    end
  endtask
  task automatic test_boundary();
    int n_click = 0, n_long = 0;
    for (int i = 0; i < 12; i++) begin
      step(i < 8, i < 8, 1'b0);
      n_click += int'(click_a) + int'(click_b);
      n_long += int'(long_a) + int'(long_b);
      checks++;
      if ({obs_a, obs_b} !== {exp_v[0], exp_v[1]}) begin
        errors++;
        $display("FAIL boundary cyc %0d got %b_%b want %b_%b", i, obs_a, obs_b, exp_v[0], exp_v[1]);
      end
    end
    checks++;
    if (n_click != 2 || n_long != 0) begin
      errors++;
      $display("FAIL boundary counts got click=%0d long=%0d want 2 0", n_click, n_long);
    end
  endtask
  task automatic test_reset_mid_hold();
    int n_rel = 0;
    for (int i = 0; i < 26; i++) begin
      step(i < 23, i < 23, i == 10);
      if (i < 23) n_rel += int'(rel_a) + int'(rel_b);
      checks++;
      if ({obs_a, obs_b} !== {exp_v[0], exp_v[1]}) begin
        errors++;
        $display("FAIL reset_mid cyc %0d got %b_%b want %b_%b", i, obs_a, obs_b, exp_v[0], exp_v[1]);
      end
    end
    checks++;
    if (n_rel != 0) begin
      errors++;
      $display("FAIL reset_mid release during hold got %0d want 0", n_rel);
    end
  endtask
  task automatic test_no_repeat();
    int n_long = 0, n_rpt = 0;
    for (int i = 0; i < 33; i++) begin
      step(1'b0, i < 30, 1'b0);
      n_long += int'(long_b);
      n_rpt += int'(rpt_b);
      checks++;
      if ({obs_a, obs_b} !== {exp_v[0], exp_v[1]}) begin
        errors++;
        $display("FAIL no_repeat cyc %0d got %b_%b want %b_%b", i, obs_a, obs_b, exp_v[0], exp_v[1]);
      end
    end
    checks++;
    if (n_long != 1 || n_rpt != 0) begin
      errors++;
      $display("FAIL no_repeat counts got long=%0d rpt=%0d want 1 0", n_long, n_rpt);
    end
  endtask
  task automatic test_random();
    bit a = 1'b0, b = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(11) == 0) a = ~a;
      if ($urandom_range(11) == 0) b = ~b;
      step(a, b, $urandom_range(149) == 0);
      checks++;
      if ({obs_a, obs_b} !== {exp_v[0], exp_v[1]}) begin
        errors++;
        $display("FAIL random cyc %0d got %b_%b want %b_%b", i, obs_a, obs_b, exp_v[0], exp_v[1]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_short_press();
    test_long_repeat();
    test_boundary();
    test_reset_mid_hold();
    test_no_repeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
